jtframe_spi_ioctl: RTL and testbench
====================================

// Module: jtframe_spi_ioctl
// PURPOSE
//  SPI slave that receives the firmware/ROM download stream driven on SPI_SCK/SPI_DI/SPI_SS2.
//  Decodes the download commands and produces the core-side download bus
//  (ioctl_download, ioctl_index, ioctl_addr, ioctl_dout, ioctl_wr).
//  This bus feeds the SDRAM ROM loader.
//  Synthesizable; SPI inputs are oversampled in the clk domain.
// PARAMETERS
//  AW      22  width of ioctl_addr in bits; the address wraps modulo 2^AW
//  SYNC    2   flip-flop stages on spi_sck, spi_di and spi_ss before edge detection (>=2)
// PORTS
//  rst             in   1   asynchronous reset, active-high
//  clk             in   1   system clock; frequency >= 4x the SPI bit rate
//  spi_sck         in   1   SPI clock; slave samples spi_di on the rising edge, MSB first
//  spi_di          in   1   SPI serial data in
//  spi_ss          in   1   slave select (SS2), active-low; frames one transaction
//  ioctl_download  out  1   high while a download is in progress
//  ioctl_index     out  8   file index set by command 0x55
//  ioctl_addr      out  AW  byte address of ioctl_dout
//  ioctl_dout      out  8   downloaded byte
//  ioctl_wr        out  1   one-cycle write strobe; ioctl_addr/ioctl_dout valid while high
//  rx_count        out  AW  bytes written since the last download start (diagnostic)
// BEHAVIOUR
//  Reset (async)
//   - All outputs 0. FSM=IDLE. Bit counter 0. Next-address register 0.
//  Input sampling
//   - spi_sck, spi_di and spi_ss each pass through SYNC flip-flops.
//   - sck_rise = synchronized sck is 1 now and was 0 on the previous cycle.
//   - spi_di is taken from the same synchronizer stage as sck, so the sampled bit is aligned with sck_rise.
//  Byte assembly
//   - While ss_s==0, each sck_rise shifts the sampled di in from the LSB side: sr <= {sr[6:0], di}.
//   - The bit counter is 3 bits; the byte is complete on the 8th rise.
//   - byte_done is a one-cycle internal pulse in the cycle after the 8th rise; the counter returns to 0.
//   - A rising edge on ss_s clears the bit counter. The partial byte is discarded and the FSM goes to IDLE.
//   - Transaction latency: ss_s falling edge to FSM=CMD takes 1 clk.
//  FSM states: IDLE, CMD, ARG_TX, ARG_IDX, DATA, SKIP
//   - IDLE: leave when ss_s falls -> CMD.
//   - CMD (first byte of a transaction), on byte_done:
//     - 0x53 -> ARG_TX
//     - 0x54 -> DATA
//     - 0x55 -> ARG_IDX
//     - any other value -> SKIP
//   - ARG_TX, on byte_done:
//     - byte!=0: ioctl_download<=1, next-address<=0, rx_count<=0.
//     - byte==0: ioctl_download<=0.
//     - Then -> SKIP.
//   - ARG_IDX, on byte_done: ioctl_index<=byte, then -> SKIP.
//     - The index is not changed while a download is in progress.
//   - DATA, on each byte_done with ioctl_download==1:
//     - ioctl_dout<=byte, ioctl_addr<=next-address, ioctl_wr<=1 for 1 clk.
//     - next-address<=next-address+1 (wraps at 2^AW); rx_count<=rx_count+1.
//     - ioctl_wr is asserted exactly 1 clk after byte_done.
//     - With ioctl_download==0, data bytes are dropped and no strobe is issued.
//   - SKIP: further bytes are ignored until ss_s rises -> IDLE.
//   - Any state -> IDLE on ss_s rising. Bytes already strobed are kept; ioctl_download is not changed.
//  Output holding
//   - ioctl_dout and ioctl_addr hold their values between strobes.
//  Downstream handshake
//   - There is no ready/stall signal. The consumer must absorb one write per 8 SPI bit times.
//  Boundary cases
//   - Download start during an active download restarts the address at 0.
//   - Second 0x53 0x00 while idle has no effect.
//   - Reset mid-byte or mid-download returns every output to 0 immediately.
//   - ss_s rising in the same cycle as byte_done: that byte completes and is processed first, then IDLE.
// TESTING
//  1. Send 0x55 0x02 in one frame -> ioctl_index==0x02; ioctl_download stays 0; no ioctl_wr.
//  2. Send 0x53 0x01 / 0x54 A5 3C 7E / 0x53 0x00 -> download rises, then falls;
//     -> 3 strobes with (addr,dout) = (0,A5) (1,3C) (2,7E); rx_count==3.
//  3. Send 0x54 11 22 with no prior download start -> zero ioctl_wr pulses.
//  4. Deassert ss after 5 bits of a data byte, then send 0x54 0x99
//     -> only 0x99 is written, at the next sequential address.
//  5. AW=4: stream 17 bytes after a download start -> the 17th write lands at addr 0.
//  6. Assert rst in the middle of a byte during a download -> all outputs 0 within 1 clk;
//     a following 0x53 0x01 0x54 0x5A -> write of 0x5A at addr 0.

Source files
------------

// File: rtl/jtframe_spi_ioctl.sv
//==============================================================================
// jtframe_spi_ioctl : SPI slave decoding the ROM download stream into the
// core-side ioctl write bus.    Revision 1.0
//==============================================================================
`default_nettype none

module jtframe_spi_ioctl #(
    parameter int AW   = 22,
    parameter int SYNC = 2
) (
    input  logic          rst,
    input  logic          clk,
    input  logic          spi_sck,
    input  logic          spi_di,
    input  logic          spi_ss,
    output logic          ioctl_download,
    output logic [7:0]    ioctl_index,
    output logic [AW-1:0] ioctl_addr,
    output logic [7:0]    ioctl_dout,
    output logic          ioctl_wr,
    output logic [AW-1:0] rx_count
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMD     = 3'd1,
        ARG_TX  = 3'd2,
        ARG_IDX = 3'd3,
        DATA    = 3'd4,
        SKIP    = 3'd5
    } state_t;

    logic [SYNC-1:0] sck_sync, di_sync, ss_sync;
    logic            sck_prev, ss_prev;
    logic            sck_s, di_s, ss_s;
    logic            sck_rise, ss_rise;
    logic [7:0]      sr;
    logic [2:0]      bit_cnt;
    logic            byte_done;
    logic [AW-1:0]   next_addr;
    state_t          state;

    // Slave select idles high, so its synchronizer resets to 1 to avoid a
    // spurious transaction start right after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sync <= '0;
            di_sync  <= '0;
            ss_sync  <= '1;
            sck_prev <= 1'b0;
            ss_prev  <= 1'b1;
        end else begin
            sck_sync <= {sck_sync[SYNC-2:0], spi_sck};
            di_sync  <= {di_sync[SYNC-2:0],  spi_di};
            ss_sync  <= {ss_sync[SYNC-2:0],  spi_ss};
            sck_prev <= sck_s;
            ss_prev  <= ss_s;
        end
    end

    assign sck_s    = sck_sync[SYNC-1];
    assign di_s     = di_sync[SYNC-1];
    assign ss_s     = ss_sync[SYNC-1];
    assign sck_rise = sck_s & ~sck_prev;
    assign ss_rise  = ss_s & ~ss_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr        <= 8'd0;
            bit_cnt   <= 3'd0;
            byte_done <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            if (ss_rise) begin
                bit_cnt <= 3'd0;
            end else if (!ss_s && sck_rise) begin
                sr        <= {sr[6:0], di_s};
                bit_cnt   <= bit_cnt + 3'd1;
                byte_done <= (bit_cnt == 3'd7);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            ioctl_download <= 1'b0;
            ioctl_index    <= 8'd0;
            ioctl_addr     <= '0;
            ioctl_dout     <= 8'd0;
            ioctl_wr       <= 1'b0;
            rx_count       <= '0;
            next_addr      <= '0;
        end else begin
            ioctl_wr <= 1'b0;
            case (state)
                IDLE: begin
                    if (!ss_s) state <= CMD;
                end
                CMD: begin
                    if (byte_done) begin
                        case (sr)
                            8'h53:   state <= ARG_TX;
                            8'h54:   state <= DATA;
                            8'h55:   state <= ARG_IDX;
                            default: state <= SKIP;
                        endcase
                    end
                end
                ARG_TX: begin
                    if (byte_done) begin
                        if (sr != 8'd0) begin
                            ioctl_download <= 1'b1;
                            next_addr      <= '0;
                            rx_count       <= '0;
                        end else begin
                            ioctl_download <= 1'b0;
                        end
                        state <= SKIP;
                    end
                end
                ARG_IDX: begin
                    if (byte_done) begin
                        if (!ioctl_download) ioctl_index <= sr;
                        state <= SKIP;
                    end
                end
                DATA: begin
                    if (byte_done && ioctl_download) begin
                        ioctl_dout <= sr;
                        ioctl_addr <= next_addr;
                        ioctl_wr   <= 1'b1;
                        next_addr  <= next_addr + AW'(1);
                        rx_count   <= rx_count + AW'(1);
                    end
                end
                SKIP: ;
                default: state <= IDLE;
            endcase
            // Placed last so a byte finishing on the closing edge is still processed
            if (ss_rise) state <= IDLE;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_jtframe_spi_ioctl.sv
//==============================================================================
// tb_jtframe_spi_ioctl : directed bench for the SPI download decoder.
// Revision 1.0
//==============================================================================
`default_nettype none

module tb_jtframe_spi_ioctl;

    logic        rst = 1'b1;
    logic        clk = 1'b0;
    logic        sck = 1'b0;
    logic        di  = 1'b0;
    logic        ss  = 1'b1;

    logic        dl, wr, dl4, wr4;
    logic [7:0]  idx, dout, idx4, dout4;
    logic [21:0] addr, rxc;
    logic [3:0]  addr4, rxc4;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] wa[$], wd[$], wa4[$], wd4[$];
    int base, base4;

    jtframe_spi_ioctl #(.AW(22), .SYNC(2)) dut (
        .rst(rst), .clk(clk), .spi_sck(sck), .spi_di(di), .spi_ss(ss),
        .ioctl_download(dl), .ioctl_index(idx), .ioctl_addr(addr),
        .ioctl_dout(dout), .ioctl_wr(wr), .rx_count(rxc)
    );

    jtframe_spi_ioctl #(.AW(4), .SYNC(2)) dut4 (
        .rst(rst), .clk(clk), .spi_sck(sck), .spi_di(di), .spi_ss(ss),
        .ioctl_download(dl4), .ioctl_index(idx4), .ioctl_addr(addr4),
        .ioctl_dout(dout4), .ioctl_wr(wr4), .rx_count(rxc4)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr)  begin wa.push_back(32'(addr));   wd.push_back(32'(dout));  end
        if (wr4) begin wa4.push_back(32'(addr4)); wd4.push_back(32'(dout4)); end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic spi_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            di = b[i];
            #40 sck = 1'b1;
            #40 sck = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] b);
        spi_bits(b, 8);
    endtask

    task automatic frame_begin();
        ss = 1'b0;
        #40;
    endtask

    task automatic frame_end();
        #40 ss = 1'b1;
        #120;
    endtask

    task automatic frame2(input logic [7:0] a, input logic [7:0] b);
        frame_begin(); spi_byte(a); spi_byte(b); frame_end();
    endtask

    initial begin
        #53;
        check("rst_dl",   32'(dl),   0);
        check("rst_wr",   32'(wr),   0);
        check("rst_idx",  32'(idx),  0);
        check("rst_addr", 32'(addr), 0);
        check("rst_dout", 32'(dout), 0);
        check("rst_rxc",  32'(rxc),  0);
        @(negedge clk) rst = 1'b0;
        #40;

        // 1: index command without download
        frame2(8'h55, 8'h02);
        check("t1_idx", 32'(idx), 32'h02);
        check("t1_dl",  32'(dl),  0);
        check("t1_nwr", 32'(wa.size()), 0);

        // 2: full download of three bytes; index locked while downloading
        frame2(8'h53, 8'h01);
        check("t2_dl_up", 32'(dl), 1);
        frame2(8'h55, 8'h07);
        check("t2_idx_lock", 32'(idx), 32'h02);
        frame_begin();
        spi_byte(8'h54); spi_byte(8'hA5); spi_byte(8'h3C); spi_byte(8'h7E);
        frame_end();
        frame2(8'h53, 8'h00);
        check("t2_dl_dn", 32'(dl), 0);
        check("t2_nwr",   32'(wa.size()), 3);
        if (wa.size() == 3) begin
            check("t2_a0", wa[0], 0); check("t2_d0", wd[0], 32'hA5);
            check("t2_a1", wa[1], 1); check("t2_d1", wd[1], 32'h3C);
            check("t2_a2", wa[2], 2); check("t2_d2", wd[2], 32'h7E);
        end
        check("t2_rxc",       32'(rxc),  3);
        check("t2_hold_addr", 32'(addr), 2);
        check("t2_hold_dout", 32'(dout), 32'h7E);
        frame2(8'h53, 8'h00);
        check("t2_dl_idle", 32'(dl), 0);

        // 3: data without a download start is dropped
        base = wa.size();
        frame_begin(); spi_byte(8'h54); spi_byte(8'h11); spi_byte(8'h22); frame_end();
        check("t3_nwr", 32'(wa.size() - base), 0);

        // 4: partial byte aborted by ss, then a clean byte at the next address
        frame2(8'h53, 8'h01);
        base = wa.size();
        frame2(8'h54, 8'hA5);
        frame_begin(); spi_byte(8'h54); spi_bits(8'hFF, 5); frame_end();
        frame2(8'h54, 8'h99);
        check("t4_nwr", 32'(wa.size() - base), 2);
        check("t4_addr", wa[wa.size()-1], 1);
        check("t4_dout", wd[wd.size()-1], 32'h99);

        // 5: address wrap with AW=4
        frame2(8'h53, 8'h01);
        base  = wa.size();
        base4 = wa4.size();
        frame_begin();
        spi_byte(8'h54);
        for (int i = 0; i < 17; i++) spi_byte(8'(8'h10 + i));
        frame_end();
        check("t5_nwr4",  32'(wa4.size() - base4), 17);
        check("t5_addr4", wa4[wa4.size()-1], 0);
        check("t5_dout4", wd4[wd4.size()-1], 32'h20);
        check("t5_rxc4",  32'(rxc4), 1);
        check("t5_addr22", wa[wa.size()-1], 16);
        check("t5_rxc22",  32'(rxc), 17);

        // 6: reset in the middle of a byte during a download
        frame_begin(); spi_byte(8'h54); spi_bits(8'hFF, 3);
        #15 rst = 1'b1;
        #1;
        check("t6_dl",   32'(dl),   0);
        check("t6_idx",  32'(idx),  0);
        check("t6_addr", 32'(addr), 0);
        check("t6_dout", 32'(dout), 0);
        check("t6_rxc",  32'(rxc),  0);
        check("t6_dl4",  32'(dl4),  0);
        ss = 1'b1; sck = 1'b0;
        #100;
        @(negedge clk) rst = 1'b0;
        #40;
        base = wa.size();
        frame2(8'h53, 8'h01);
        frame2(8'h54, 8'h5A);
        check("t6_nwr",  32'(wa.size() - base), 1);
        check("t6_waddr", wa[wa.size()-1], 0);
        check("t6_wdout", wd[wd.size()-1], 32'h5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
